ring_phase_monitor: RTL

// - Downstream consumer of the 4-bit one-hot ring counter output; sits beside it on the same clock.
// - Samples ring_in every cycle, converts the one-hot phase to a binary index and counts full rotations.
// - Checks each step against the legal rotate-right sequence 0001->1000->0100->0010->0001.
// - Flags and counts illegal codes and illegal steps.

---
 rtl/ring_phase_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ring_phase_monitor.sv
// Watches a one-hot rotate-right ring counter: reports phase, counts rotations, flags illegal codes/steps.
// Optional RING_AUTO_RESYNC_EN: leave FAULT on its own once the ring shows a one-hot code again.
module ring_phase_monitor #(
    parameter int W   = 4,
    parameter int RCW = 8,
    parameter int ECW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 preset,
    input  logic [W-1:0]         ring_in,
    output logic [$clog2(W)-1:0] phase_idx,
    output logic                 phase_vld,
    output logic                 wrap,
    output logic [RCW-1:0]       rot_count,
    output logic                 err,
    output logic [ECW-1:0]       err_count,
    output logic [1:0]           state
);
    // state | meaning
    // IDLE  | ring quiet (all zero), nothing tracked yet
    // SYNC  | one legal one-hot seen, waiting for the first legal step
    // TRACK | locked: every sample must be the rotate-right of the last
    // FAULT | illegal code or step seen; phase_idx frozen
    localparam int PW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        TRACK = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t         st;
    logic [W-1:0]   prev;
    logic [W-1:0]   exp_prev;
    logic           oh;
    logic           fault_hit;
    logic           wrap_hit;
    logic [PW-1:0]  cur_idx;

    function automatic logic is_onehot(input logic [W-1:0] x);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) n = n + int'(x[i]);
        return n == 1;
    endfunction

    function automatic logic [PW-1:0] idx_of(input logic [W-1:0] x);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) if (x[i]) r = PW'(i);
        return r;
    endfunction

    always_comb begin
        exp_prev  = {prev[0], prev[W-1:1]};
        oh        = is_onehot(ring_in);
        cur_idx   = idx_of(ring_in);
        fault_hit = 1'b0;
        wrap_hit  = 1'b0;
        case (st)
            IDLE:  fault_hit = (ring_in != '0) && !oh;
            // prev is one-hot here, so matching exp_prev implies a one-hot sample
            SYNC:  fault_hit = (ring_in != exp_prev) && !(preset && ring_in == prev);
            TRACK: begin
                if (preset) begin
                    fault_hit = (ring_in != W'(1));
                end else begin
                    fault_hit = (ring_in != exp_prev);
                    wrap_hit  = !fault_hit && prev[0];
                end
            end
            FAULT: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            prev      <= '0;
            phase_idx <= '0;
            phase_vld <= 1'b0;
            wrap      <= 1'b0;
            rot_count <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            wrap <= wrap_hit;
            err  <= fault_hit;
            if (wrap_hit && !(&rot_count)) rot_count <= rot_count + RCW'(1);
            if (fault_hit && !(&err_count)) err_count <= err_count + ECW'(1);

            if (fault_hit) begin
                st        <= FAULT;
                phase_vld <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (oh) begin
                            st        <= SYNC;
                            prev      <= ring_in;
                            phase_idx <= cur_idx;
                        end
                    end
                    SYNC: begin
                        if (ring_in == exp_prev) begin
                            st        <= TRACK;
                            prev      <= ring_in;
                            phase_idx <= cur_idx;
                            phase_vld <= 1'b1;
                        end
                    end
                    TRACK: begin
                        // covers both a legal step and a preset reload onto bit0
                        prev      <= ring_in;
                        phase_idx <= cur_idx;
                    end
                    FAULT: begin
                        if (preset && oh) begin
                            st        <= SYNC;
                            prev      <= ring_in;
                            phase_idx <= cur_idx;
                        end else if (preset) begin
                            st   <= IDLE;
                            prev <= '0;
                        end
`ifdef RING_AUTO_RESYNC_EN
                        else if (oh) begin
                            st        <= SYNC;
                            prev      <= ring_in;
                            phase_idx <= cur_idx;
                        end
`endif
                    end
                endcase
            end
        end
    end

    assign state = st;

endmodule
